// File: rtl/io_mem_responder.sv
// io_mem_responder: byte-serial instruction/data responder for the CPU-side IO controller.
// Build option RESP_RANGE_CHECK_EN: flag and suppress accesses outside the 128-byte window.
//
// state     | meaning
// IDLE      | one-cycle gap between instructions
// SEND_INST | stream mem[pc] LSB first, then a 0x00 pad byte
// EXEC      | latch op flags, advance pc
// COLLECT   | discard one byte, then assemble address and store-data words
// SEND_DATA | stream mem[addr_reg] LSB first, then a 0x00 pad byte
module io_mem_responder (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  addr_in,
    input  logic [7:0]  wdata_in,
    input  logic        cpu_clk_in,
    input  logic        op_load,
    input  logic        op_store,
    input  logic        op_jump,
    input  logic        prog_we,
    input  logic [4:0]  prog_addr,
    input  logic [31:0] prog_data,
    output logic [7:0]  data_out,
    output logic [2:0]  phase,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_INST = 3'd1,
        EXEC      = 3'd2,
        COLLECT   = 3'd3,
        SEND_DATA = 3'd4
    } state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [31:0] pc;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        ld_f;
    logic        st_f;
    logic        jp_f;
    logic [31:0] mem [0:31];
    logic [31:0] rd_word;

    logic [31:0] addr_full;
    logic [31:0] wdata_full;
    logic        last_byte;
    logic        store_en;
    logic        pc_ok;
    logic        addr_ok;
    logic        rd_ok;

    // The final byte is used straight off the bus so the store/jump lands on the last COLLECT edge.
    assign addr_full  = {addr_in, addr_reg[23:0]};
    assign wdata_full = {wdata_in, wdata_reg[23:0]};
    assign last_byte  = (state == COLLECT) && (cnt == 3'd4);
    assign store_en   = rst && last_byte && st_f && addr_ok;
    assign phase      = state;

`ifdef RESP_RANGE_CHECK_EN
    assign pc_ok   = (pc[31:7] == 25'd0);
    assign addr_ok = (addr_full[31:7] == 25'd0);
    assign rd_ok   = (addr_reg[31:7] == 25'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (((state == SEND_INST) && !pc_ok) || (last_byte && !addr_ok)) begin
            err <= 1'b1;
        end
    end
`else
    assign pc_ok   = 1'b1;
    assign addr_ok = 1'b1;
    assign rd_ok   = 1'b1;
    assign err     = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{cpu_clk_in, addr_reg[31:24], wdata_reg[31:24]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pc        <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            ld_f      <= 1'b0;
            st_f      <= 1'b0;
            jp_f      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= SEND_INST;
                    cnt   <= '0;
                end
                SEND_INST: begin
                    if (cnt == 3'd4) begin
                        state <= EXEC;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                EXEC: begin
                    ld_f  <= op_load;
                    st_f  <= op_store;
                    jp_f  <= op_jump;
                    pc    <= pc + 32'd4;
                    cnt   <= '0;
                    state <= (op_load || op_store || op_jump) ? COLLECT : IDLE;
                end
                COLLECT: begin
                    case (cnt)
                        3'd1: begin
                            addr_reg[7:0]  <= addr_in;
                            wdata_reg[7:0] <= wdata_in;
                        end
                        3'd2: begin
                            addr_reg[15:8]  <= addr_in;
                            wdata_reg[15:8] <= wdata_in;
                        end
                        3'd3: begin
                            addr_reg[23:16]  <= addr_in;
                            wdata_reg[23:16] <= wdata_in;
                        end
                        3'd4: begin
                            addr_reg[31:24]  <= addr_in;
                            wdata_reg[31:24] <= wdata_in;
                        end
                        default: ;
                    endcase
                    if (cnt == 3'd4) begin
                        if (jp_f) begin
                            pc <= addr_full;
                        end
                        state <= ld_f ? SEND_DATA : SEND_INST;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                SEND_DATA: begin
                    if (cnt == 3'd4) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Program port is listed second so it overrides a same-word store in the same cycle.
    always_ff @(posedge clk) begin
        if (store_en) begin
            mem[addr_full[6:2]] <= wdata_full;
        end
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        rd_word  = '0;
        data_out = '0;
        if ((state == SEND_INST) && pc_ok) begin
            rd_word = mem[pc[6:2]];
        end else if ((state == SEND_DATA) && rd_ok) begin
            rd_word = mem[addr_reg[6:2]];
        end
        if (rst && (cnt < 3'd4)) begin
            data_out = rd_word[{cnt[1:0], 3'b000} +: 8];
        end
    end

endmodule

// File: tb/tb_io_mem_responder.sv
// Bench for io_mem_responder: transaction-level model producing per-cycle expectations,
// one compare process, and literal byte checks on the observed streams.
module tb_io_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  addr_in = '0;
    logic [7:0]  wdata_in = '0;
    logic        cpu_clk_in = 1'b0;
    logic        op_load = 1'b0;
    logic        op_store = 1'b0;
    logic        op_jump = 1'b0;
    logic        prog_we = 1'b0;
    logic [4:0]  prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic [7:0]  data_out;
    logic [2:0]  phase;
    logic        err;

    io_mem_responder dut (
        .clk(clk), .rst(rst), .addr_in(addr_in), .wdata_in(wdata_in),
        .cpu_clk_in(cpu_clk_in), .op_load(op_load), .op_store(op_store), .op_jump(op_jump),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .data_out(data_out), .phase(phase), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] ph;
        logic [7:0] d;
        logic       e;
    } exp_t;

    int          tests = 0;
    int          fails = 0;
    exp_t        expq[$];
    exp_t        cur;
    logic [7:0]  hist[$];
    logic [31:0] mmem [32];
    logic [31:0] mpc;
    logic        merr;

    function automatic logic [31:0] init_word(input int i);
        if (i == 0)  return 32'h11223344;
        if (i == 1)  return 32'h55667788;
        if (i == 16) return 32'hCAFEF00D;
        return {4{8'(i)}} ^ 32'hA5A5A5A5;
    endfunction

    function automatic bit in_range(input logic [31:0] a);
`ifdef RESP_RANGE_CHECK_EN
        return a[31:7] == 25'd0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [31:0] mword(input logic [31:0] a);
        if (!in_range(a)) return 32'd0;
        return mmem[a[6:2]];
    endfunction

    always @(negedge clk) begin
        if (expq.size() != 0) begin
            cur = expq.pop_front();
            tests++;
            if (phase !== cur.ph || data_out !== cur.d || err !== cur.e) begin
                fails++;
                $display("FAIL cycle_check t=%0t: phase/data/err got %0d/%02h/%0b want %0d/%02h/%0b",
                         $time, phase, data_out, err, cur.ph, cur.d, cur.e);
            end
            if (phase == 3'd1 || phase == 3'd4) hist.push_back(data_out);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        op_load    = 1'b0;
        op_store   = 1'b0;
        op_jump    = 1'b0;
        prog_we    = 1'b0;
        addr_in    = 8'($urandom);
        wdata_in   = 8'($urandom);
        cpu_clk_in = 1'($urandom);
    endtask

    task automatic push(input logic [2:0] ph, input logic [7:0] d);
        exp_t x;
        x.ph = ph;
        x.d  = d;
        x.e  = merr;
        expq.push_back(x);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %02h want %02h", name, got, want);
        end
    endtask

    task automatic chk_word(input string name, input int base, input logic [31:0] want);
        logic [7:0] got;
        for (int j = 0; j < 4; j++) begin
            got = (base + j < hist.size()) ? hist[base + j] : 8'hxx;
            chk8(name, got, want[8*j +: 8]);
        end
    endtask

    task automatic do_reset(input int n);
        rst  = 1'b0;
        mpc  = '0;
        merr = 1'b0;
        for (int k = 0; k < n; k++) begin
            tick();
            push(3'd0, 8'h00);
            if (k == n - 1) rst = 1'b1;
        end
    endtask

    task automatic do_instr(input bit from_idle, input bit ld, input bit st, input bit jp,
                            input logic [31:0] a, input logic [31:0] wd,
                            input bit coll, input logic [31:0] cdata, input bit abort,
                            output bit next_idle);
        logic [31:0] w;
        hist.delete();
        if (from_idle) begin
            tick();
            push(3'd0, 8'h00);
        end
        w = mword(mpc);
        for (int i = 0; i < 4; i++) begin
            tick();
            push(3'd1, w[8*i +: 8]);
            if (i == 0 && !in_range(mpc)) merr = 1'b1;
        end
        tick();
        push(3'd1, 8'h00);
        tick();
        push(3'd2, 8'h00);
        op_load  = ld;
        op_store = st;
        op_jump  = jp;
        mpc = mpc + 32'd4;
        if (!(ld || st || jp)) begin
            next_idle = 1'b1;
            return;
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            push(3'd3, 8'h00);
            if (c >= 1) begin
                addr_in  = a[8*(c-1) +: 8];
                wdata_in = wd[8*(c-1) +: 8];
            end
            if (c == 4) begin
                if (coll) begin
                    prog_we   = 1'b1;
                    prog_addr = a[6:2];
                    prog_data = cdata;
                end
                if (abort) rst = 1'b0;
            end
        end
        if (abort) begin
            next_idle = 1'b0;
            return;
        end
        if (st && in_range(a)) mmem[a[6:2]] = wd;
        if (coll) mmem[a[6:2]] = cdata;
        if (jp) mpc = a;
        if (!in_range(a)) merr = 1'b1;
        if (ld) begin
            w = mword(a);
            for (int i = 0; i < 4; i++) begin
                tick();
                push(3'd4, w[8*i +: 8]);
            end
            tick();
            push(3'd4, 8'h00);
            next_idle = 1'b1;
        end else begin
            next_idle = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit ni;
        mpc  = '0;
        merr = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            push(3'd0, 8'h00);
            prog_we   = 1'b1;
            prog_addr = 5'(i);
            prog_data = init_word(i);
            mmem[i]   = init_word(i);
        end
        do_reset(2);

        do_instr(1'b0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, ni);
        settle();
        chk_word("fetch_mem0", 0, 32'h11223344);
        chk8("fetch_mem0_pad", hist[4], 8'h00);

        do_instr(ni, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, ni);
        settle();
        chk_word("fetch_mem1", 0, 32'h55667788);

        do_instr(ni, 0, 1, 0, 32'h00000008, 32'hDEADBEEF, 0, 32'h0, 0, ni);
        do_instr(ni, 1, 0, 0, 32'h00000008, 32'h0, 0, 32'h0, 0, ni);
        settle();
        chk_word("load_after_store", 5, 32'hDEADBEEF);
        chk8("load_pad", hist[9], 8'h00);

        do_instr(ni, 0, 0, 1, 32'h00000040, 32'h0, 0, 32'h0, 0, ni);
        do_instr(ni, 0, 1, 0, 32'h0000000C, 32'h11111111, 1, 32'h5A5A5A5A, 0, ni);
        settle();
        chk_word("fetch_after_jump", 0, 32'hCAFEF00D);

        do_instr(ni, 1, 1, 0, 32'h00000014, 32'h01020304, 0, 32'h0, 0, ni);
        settle();
        chk_word("load_store_same", 5, 32'h01020304);

        do_instr(ni, 1, 0, 1, 32'h0000000C, 32'h0, 0, 32'h0, 0, ni);
        settle();
        chk_word("collision_prog_wins", 5, 32'h5A5A5A5A);

        do_instr(ni, 0, 1, 0, 32'h00000100, 32'h0BADF00D, 0, 32'h0, 0, ni);
        do_instr(ni, 1, 0, 0, 32'h00000000, 32'h0, 0, 32'h0, 0, ni);
        settle();
`ifdef RESP_RANGE_CHECK_EN
        chk_word("store_high_addr", 5, 32'h11223344);
        chk8("err_after_high_store", {7'd0, err}, 8'h01);
`else
        chk_word("store_high_addr", 5, 32'h0BADF00D);
        chk8("err_after_high_store", {7'd0, err}, 8'h00);
`endif

        do_instr(ni, 0, 1, 0, 32'h00000018, 32'hFFFFFFFF, 0, 32'h0, 1, ni);
        do_reset(3);
        do_instr(1'b0, 1, 0, 0, 32'h00000018, 32'h0, 0, 32'h0, 0, ni);
        settle();
        chk_word("abort_no_store", 5, 32'hA3A3A3A3);
        chk8("err_cleared_by_reset", {7'd0, err}, 8'h00);

        do_instr(ni, 0, 0, 1, 32'h00000200, 32'h0, 0, 32'h0, 0, ni);
        do_instr(ni, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, ni);
        settle();
`ifdef RESP_RANGE_CHECK_EN
        chk_word("fetch_high_pc", 0, 32'h00000000);
        chk8("err_after_high_fetch", {7'd0, err}, 8'h01);
`else
        chk_word("fetch_high_pc", 0, 32'h0BADF00D);
        chk8("err_after_high_fetch", {7'd0, err}, 8'h00);
`endif

        tick();
        settle();
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL expect_queue_drain: got %0d pending want 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
